// File: rtl/lpc_record_serializer.sv
// lpc_record_serializer: pops DW-bit ringbuffer records and streams them byte-wise (binary or ASCII hex) to uart_tx,
// with an optional terminator byte and a saturating overflow-event counter.
module lpc_record_serializer #(
    parameter int          DW        = 48,
    parameter int          HEX_MODE  = 0,
    parameter int          LSB_FIRST = 0,
    parameter int          TERM_EN   = 1,
    parameter logic [7:0]  TERM_BYTE = 8'h0A,
    parameter int          CW        = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          read_empty,
    output logic          read_clock_enable,
    input  logic [DW-1:0] read_data,
    input  logic          overflow,
    input  logic          uart_ready,
    output logic          uart_clock_enable,
    output logic [7:0]    uart_data,
    output logic          busy,
    output logic [CW-1:0] drop_count
);
    localparam int SW = (HEX_MODE != 0) ? 4 : 8;
    localparam int N  = DW / SW;
    localparam int NW = $clog2(N + 2);

    // POP is the cycle the strobe is high; the ringbuffer presents data during FETCH
    typedef enum logic [2:0] {IDLE, POP, FETCH, SEND, GUARD, TERM} state_t;

    state_t        state_q, state_d;
    logic          rce_q, rce_d;
    logic          uce_q, uce_d;
    logic [7:0]    ud_q, ud_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] sh_q, sh_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic          term_q, term_d;
    logic          ov_q;
    logic [CW-1:0] drop_q;
    logic [3:0]    nib;
    logic [7:0]    byt;
    logic [7:0]    sym;

    always_comb begin
        nib = (LSB_FIRST != 0) ? sh_q[3:0] : sh_q[DW-1 -: 4];
        byt = (LSB_FIRST != 0) ? sh_q[7:0] : sh_q[DW-1 -: 8];
        sym = (HEX_MODE != 0) ? ((nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib}) : byt;
    end

    always_comb begin
        state_d = state_q;
        rce_d   = 1'b0;
        uce_d   = 1'b0;
        ud_d    = ud_q;
        busy_d  = busy_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        term_d  = term_q;
        case (state_q)
            IDLE: begin
                if (!read_empty) begin
                    rce_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = POP;
                end
            end
            POP: state_d = FETCH;
            FETCH: begin
                sh_d    = read_data;
                cnt_d   = NW'(N);
                term_d  = 1'b0;
                state_d = SEND;
            end
            SEND: begin
                if (uart_ready) begin
                    ud_d    = sym;
                    uce_d   = 1'b1;
                    sh_d    = (LSB_FIRST != 0) ? sh_q >> SW : sh_q << SW;
                    cnt_d   = cnt_q - NW'(1);
                    state_d = GUARD;
                end
            end
            // uart_ready is deliberately ignored here: uart_tx may drop ready one cycle late
            GUARD: begin
                if (cnt_q != '0) begin
                    state_d = SEND;
                end else if (TERM_EN != 0 && !term_q) begin
                    state_d = TERM;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            TERM: begin
                if (uart_ready) begin
                    ud_d    = TERM_BYTE;
                    uce_d   = 1'b1;
                    term_d  = 1'b1;
                    state_d = GUARD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rce_q   <= 1'b0;
            uce_q   <= 1'b0;
            ud_q    <= 8'h00;
            busy_q  <= 1'b0;
            sh_q    <= '0;
            cnt_q   <= '0;
            term_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rce_q   <= rce_d;
            uce_q   <= uce_d;
            ud_q    <= ud_d;
            busy_q  <= busy_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            term_q  <= term_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ov_q   <= 1'b0;
            drop_q <= '0;
        end else begin
            ov_q <= overflow;
            if (overflow && !ov_q && drop_q != '1) drop_q <= drop_q + CW'(1);
        end
    end

    assign read_clock_enable = rce_q;
    assign uart_clock_enable = uce_q;
    assign uart_data         = ud_q;
    assign busy              = busy_q;
    assign drop_count        = drop_q;
endmodule

// File: tb/tb_lpc_record_serializer.sv
// tb_lpc_record_serializer: four serializer configurations fed from a ringbuffer model and checked against expected byte streams.
module tb_lpc_record_serializer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic uart_ready = 1'b1;
    logic overflow = 1'b0;
    always #5 clock = ~clock;

    logic [3:0]  rempty, rce, uce, busy;
    logic [47:0] rdata [4];
    logic [7:0]  ud [4];
    logic [15:0] dc0, dc1, dc3;
    logic [1:0]  dc2;

    // d0 bin/MSB/term 0A, d1 hex/MSB/term 0A, d2 bin/LSB/no term/CW=2, d3 hex/LSB/term 0D
    lpc_record_serializer #(.DW(48), .HEX_MODE(0), .LSB_FIRST(0), .TERM_EN(1), .TERM_BYTE(8'h0A), .CW(16)) d0 (
        .clock(clock), .reset(reset), .read_empty(rempty[0]), .read_clock_enable(rce[0]), .read_data(rdata[0]),
        .overflow(overflow), .uart_ready(uart_ready), .uart_clock_enable(uce[0]), .uart_data(ud[0]), .busy(busy[0]), .drop_count(dc0));
    lpc_record_serializer #(.DW(48), .HEX_MODE(1), .LSB_FIRST(0), .TERM_EN(1), .TERM_BYTE(8'h0A), .CW(16)) d1 (
        .clock(clock), .reset(reset), .read_empty(rempty[1]), .read_clock_enable(rce[1]), .read_data(rdata[1]),
        .overflow(overflow), .uart_ready(uart_ready), .uart_clock_enable(uce[1]), .uart_data(ud[1]), .busy(busy[1]), .drop_count(dc1));
    lpc_record_serializer #(.DW(48), .HEX_MODE(0), .LSB_FIRST(1), .TERM_EN(0), .TERM_BYTE(8'h0A), .CW(2)) d2 (
        .clock(clock), .reset(reset), .read_empty(rempty[2]), .read_clock_enable(rce[2]), .read_data(rdata[2]),
        .overflow(overflow), .uart_ready(uart_ready), .uart_clock_enable(uce[2]), .uart_data(ud[2]), .busy(busy[2]), .drop_count(dc2));
    lpc_record_serializer #(.DW(48), .HEX_MODE(1), .LSB_FIRST(1), .TERM_EN(1), .TERM_BYTE(8'h0D), .CW(16)) d3 (
        .clock(clock), .reset(reset), .read_empty(rempty[3]), .read_clock_enable(rce[3]), .read_data(rdata[3]),
        .overflow(overflow), .uart_ready(uart_ready), .uart_clock_enable(uce[3]), .uart_data(ud[3]), .busy(busy[3]), .drop_count(dc3));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
        end
    endtask

    // ringbuffer model: registered read, data valid the cycle after the pop strobe
    logic [47:0] ring [4][16];
    int rw [4];
    int rr [4];
    always_comb for (int k = 0; k < 4; k++) rempty[k] = (rw[k] == rr[k]);
    always @(posedge clock)
        for (int k = 0; k < 4; k++)
            if (rce[k]) begin
                rdata[k] <= ring[k][rr[k] % 16];
                rr[k] <= rr[k] + 1;
            end

    // expected byte stream per instance
    logic [7:0] exm [4][256];
    int ew [4];
    int er [4];
    int npop [4];
    int sc0 = 0;
    int strobes = 0;
    string hx = "0123456789ABCDEF";

    task automatic push(input logic [47:0] rec);
        for (int k = 0; k < 4; k++) begin
            bit hex = (k % 2) == 1;
            bit lsb = k >= 2;
            int n = hex ? 12 : 6;
            int w = hex ? 4 : 8;
            ring[k][rw[k] % 16] = rec;
            rw[k]++;
            for (int i = 0; i < n; i++) begin
                int j = lsb ? i : n - 1 - i;
                int v = int'((rec >> (j * w)) & (hex ? 48'hF : 48'hFF));
                exm[k][ew[k] % 256] = hex ? hx[v] : 8'(v);
                ew[k]++;
            end
            if (k != 2) begin
                exm[k][ew[k] % 256] = (k == 3) ? 8'h0D : 8'h0A;
                ew[k]++;
            end
        end
    endtask

    logic       prev_ready = 1'b1;
    logic [3:0] prev_uce = '0, prev_busy = '0, prev_rce = '0;
    always @(negedge clock) begin
        if (!reset)
            for (int k = 0; k < 4; k++) begin
                if (uce[k]) begin
                    chk("strobe_ready", 64'(prev_ready), 64'd1);
                    chk("strobe_gap", 64'(prev_uce[k]), 64'd0);
                    chk("byte_pending", 64'(ew[k] > er[k]), 64'd1);
                    if (ew[k] > er[k]) begin
                        chk($sformatf("byte_d%0d", k), 64'(ud[k]), 64'(exm[k][er[k] % 256]));
                        er[k]++;
                    end
                    strobes++;
                    if (k == 0) sc0++;
                end
                if (rce[k]) begin
                    chk("pop_nonempty", 64'(rempty[k]), 64'd0);
                    chk("pop_not_busy", 64'(prev_busy[k]), 64'd0);
                    chk("pop_gap", 64'(prev_rce[k]), 64'd0);
                    npop[k]++;
                end
            end
        prev_ready = uart_ready;
        prev_uce = uce;
        prev_busy = busy;
        prev_rce = rce;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    function automatic bit all_done();
        bit d = (rempty == 4'hF) && (busy == 4'h0);
        for (int k = 0; k < 4; k++) d = d && (er[k] == ew[k]);
        return d;
    endfunction

    task automatic wait_done(input bit rnd);
        int n = 0;
        while (!all_done() && n < 3000) begin
            tick(1);
            if (rnd) uart_ready = ($urandom_range(0, 3) != 0);
            n++;
        end
        uart_ready = 1'b1;
        chk("done_in_time", 64'(n < 3000), 64'd1);
        for (int k = 0; k < 4; k++) begin
            chk("drained", 64'(ew[k] - er[k]), 64'd0);
            chk("busy_low", 64'(busy[k]), 64'd0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rce"}, 64'(rce), 64'd0);
        chk({tag, "_uce"}, 64'(uce), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        for (int k = 0; k < 4; k++) chk({tag, "_data"}, 64'(ud[k]), 64'd0);
        chk({tag, "_drop0"}, 64'(dc0), 64'd0);
        chk({tag, "_drop2"}, 64'(dc2), 64'd0);
    endtask

    initial begin
        int p [4];
        int s, n, base;
        tick(3);
        chk_zero("reset");
        reset = 1'b0;
        tick(2);
        // single record, binary/hex views of the same value
        for (int k = 0; k < 4; k++) p[k] = npop[k];
        push(48'h123456789ABC);
        wait_done(0);
        for (int k = 0; k < 4; k++) chk("one_pop", 64'(npop[k] - p[k]), 64'd1);
        push(48'h00A5FF0B1C2D);
        wait_done(0);
        // ready held low: everything stalls mid-record
        uart_ready = 1'b0;
        push(48'({$urandom(), $urandom()}));
        tick(6);
        s = strobes;
        tick(25);
        chk("stall_no_strobe", 64'(strobes - s), 64'd0);
        chk("stall_busy", 64'(busy), 64'hF);
        uart_ready = 1'b1;
        wait_done(0);
        // back-to-back records with random backpressure
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 4; k++) p[k] = npop[k];
            push(48'({$urandom(), $urandom()}));
            tick($urandom_range(0, 10));
            push(48'({$urandom(), $urandom()}));
            wait_done(1);
            for (int k = 0; k < 4; k++) chk("two_pops", 64'(npop[k] - p[k]), 64'd2);
        end
        // overflow edges: 3 pulses then a long high level
        repeat (3) begin
            overflow = 1'b1; tick(1);
            overflow = 1'b0; tick(1);
        end
        overflow = 1'b1; tick(10);
        overflow = 1'b0; tick(2);
        chk("drop_cw16", 64'(dc0), 64'd4);
        chk("drop_cw16_hex", 64'(dc1), 64'd4);
        chk("drop_cw2_sat", 64'(dc2), 64'd3);
        overflow = 1'b1; tick(1);
        overflow = 1'b0; tick(2);
        chk("drop_cw16_5", 64'(dc0), 64'd5);
        chk("drop_cw2_5", 64'(dc2), 64'd3);
        // asynchronous reset after the third byte of a record
        base = sc0;
        push(48'hCAFEF00D1234);
        n = 0;
        while (sc0 < base + 3 && n < 500) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk("third_byte_seen", 64'(n < 500), 64'd1);
        #2 reset = 1'b1;
        #1 chk_zero("async_reset");
        for (int k = 0; k < 4; k++) er[k] = ew[k];
        tick(2);
        reset = 1'b0;
        s = strobes;
        for (int k = 0; k < 4; k++) p[k] = npop[k];
        tick(20);
        chk("post_reset_quiet", 64'(strobes - s), 64'd0);
        for (int k = 0; k < 4; k++) chk("post_reset_no_pop", 64'(npop[k] - p[k]), 64'd0);
        push(48'h0123456789EF);
        wait_done(0);
        for (int k = 0; k < 4; k++) chk("fresh_pop", 64'(npop[k] - p[k]), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
